// File: rtl/alu_exec_unit.sv
// Execute stage: per-phase ALU, destination load-code selection and a
// four-digit hex display of EAX[15:0].
module alu_exec_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              phase1_en,
    input  logic              phase2_en,
    input  logic              phase3_en,
    input  logic [31:0]       ope,
    input  logic [DATA_W-1:0] operand,
    input  logic [3:0]        num_of_ope,
    input  logic [DATA_W-1:0] zero,
    input  logic [DATA_W-1:0] eax,
    input  logic [3:0]        reg_load_1,
    input  logic [3:0]        reg_load_2,
    input  logic [3:0]        reg_load_3,
    output logic [DATA_W-1:0] alu_result_bus,
    output logic [3:0]        selected_reg_load,
    output logic [7:0]        seg7_1,
    output logic [7:0]        seg7_2,
    output logic [7:0]        seg7_3,
    output logic [7:0]        seg7_4
);

    localparam logic [7:0] OP_ADD    = 8'h01;
    localparam logic [7:0] OP_SUB    = 8'h29;
    localparam logic [7:0] OP_CMP    = 8'h3D;
    localparam logic [7:0] OP_JE     = 8'h74;
    localparam logic [7:0] OP_JNE    = 8'h75;
    localparam logic [7:0] OP_ADDI   = 8'h83;
    localparam logic [7:0] OP_MOV_MR = 8'h89;
    localparam logic [7:0] OP_MOV_RM = 8'h8B;
    localparam logic [7:0] OP_JMP    = 8'hEB;

    function automatic logic [7:0] seg7_digit(input logic [3:0] d);
        case (d)
            4'h0: seg7_digit = 8'hC0;
            4'h1: seg7_digit = 8'hF9;
            4'h2: seg7_digit = 8'hA4;
            4'h3: seg7_digit = 8'hB0;
            4'h4: seg7_digit = 8'h99;
            4'h5: seg7_digit = 8'h92;
            4'h6: seg7_digit = 8'h82;
            4'h7: seg7_digit = 8'hF8;
            4'h8: seg7_digit = 8'h80;
            4'h9: seg7_digit = 8'h90;
            4'hA: seg7_digit = 8'h88;
            4'hB: seg7_digit = 8'h83;
            4'hC: seg7_digit = 8'hC6;
            4'hD: seg7_digit = 8'hA1;
            4'hE: seg7_digit = 8'h86;
            default: seg7_digit = 8'h8E;
        endcase
    endfunction

    logic [7:0]               opcode;
    logic signed [DATA_W-1:0] sx;
    logic [DATA_W-1:0]        num_ext;
    logic [DATA_W-1:0]        pc_next;
    logic [DATA_W-1:0]        result_p0;
    logic [3:0]               load_p0;
    logic                     vld_p0;
    logic [DATA_W-1:0]        result_p1;
    logic [3:0]               load_p1;
    logic [DATA_W-1:0]        temp_p1;
    logic                     unused_ope;

    assign unused_ope = ^ope[15:0];

    // Stage 0: decode and compute the result for the active phase
    always_comb begin
        opcode    = ope[31:24];
        sx        = {{(DATA_W-8){ope[23]}}, ope[23:16]};
        num_ext   = {{(DATA_W-4){1'b0}}, num_of_ope};
        pc_next   = operand + num_ext;
        result_p0 = pc_next;
        vld_p0    = phase1_en | phase2_en | phase3_en;
        // Phase 1 wins over 2, and 2 over 3, when strobes overlap
        if (phase1_en)
            load_p0 = reg_load_1;
        else if (phase2_en)
            load_p0 = reg_load_2;
        else
            load_p0 = reg_load_3;

        case (opcode) inside
            OP_MOV_MR, OP_MOV_RM: result_p0 = operand;
            OP_ADDI:              result_p0 = operand + sx;
            OP_ADD:               result_p0 = phase1_en ? operand : temp_p1 + operand;
            OP_SUB:               result_p0 = phase1_en ? operand : temp_p1 - operand;
            OP_CMP:               result_p0 = eax - sx;
            [8'h40:8'h47]:        result_p0 = operand + 1'b1;
            [8'h48:8'h4F]:        result_p0 = operand - 1'b1;
            [8'h50:8'h57]:        result_p0 = phase1_en ? operand - DATA_W'(4) : operand;
            [8'h58:8'h5F]:        result_p0 = phase1_en ? operand : operand + DATA_W'(4);
            OP_JMP:               result_p0 = pc_next + sx;
            OP_JE:                result_p0 = (zero == '0) ? pc_next + sx : pc_next;
            OP_JNE:               result_p0 = (zero != '0) ? pc_next + sx : pc_next;
            default:              result_p0 = pc_next;
        endcase
    end

    // Stage 1: registered result, load code and the phase-1 operand latch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_p1 <= '0;
            load_p1   <= 4'h0;
            temp_p1   <= '0;
        end else if (vld_p0) begin
            result_p1 <= result_p0;
            load_p1   <= load_p0;
            if (phase1_en)
                temp_p1 <= operand;
        end
    end

    assign alu_result_bus    = result_p1;
    assign selected_reg_load = load_p1;

    assign seg7_1 = seg7_digit(eax[3:0]);
    assign seg7_2 = seg7_digit(eax[7:4]);
    assign seg7_3 = seg7_digit(eax[11:8]);
    assign seg7_4 = seg7_digit(eax[15:12]);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit with hand-computed expectations.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        phase1_en = 1'b0, phase2_en = 1'b0, phase3_en = 1'b0;
    logic [31:0] ope = '0, operand = '0, zero = '0, eax = '0;
    logic [3:0]  num_of_ope = '0;
    logic [3:0]  reg_load_1 = '0, reg_load_2 = '0, reg_load_3 = '0;
    logic [31:0] alu_result_bus;
    logic [3:0]  selected_reg_load;
    logic [7:0]  seg7_1, seg7_2, seg7_3, seg7_4;

    int n_vec = 0;
    int n_miscmp = 0;

    logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    alu_exec_unit #(.DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .phase1_en(phase1_en), .phase2_en(phase2_en), .phase3_en(phase3_en),
        .ope(ope), .operand(operand), .num_of_ope(num_of_ope),
        .zero(zero), .eax(eax),
        .reg_load_1(reg_load_1), .reg_load_2(reg_load_2), .reg_load_3(reg_load_3),
        .alu_result_bus(alu_result_bus), .selected_reg_load(selected_reg_load),
        .seg7_1(seg7_1), .seg7_2(seg7_2), .seg7_3(seg7_3), .seg7_4(seg7_4)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // One-cycle strobe; returns on the falling edge after the sampling edge
    task automatic pulse(input logic a, input logic b, input logic c);
        @(negedge clk);
        phase1_en = a; phase2_en = b; phase3_en = c;
        @(negedge clk);
        phase1_en = 1'b0; phase2_en = 1'b0; phase3_en = 1'b0;
    endtask

    initial begin
        // async reset before any clock edge
        #3 reset = 1'b1;
        #1;
        check_vec("rst_result", alu_result_bus, 32'h0);
        check_vec("rst_load", {28'h0, selected_reg_load}, 32'h0);
        eax = 32'h0000_1234;
        #0.5;
        check_vec("seg7_4", {24'h0, seg7_4}, 32'hF9);
        check_vec("seg7_3", {24'h0, seg7_3}, 32'hA4);
        check_vec("seg7_2", {24'h0, seg7_2}, 32'hB0);
        check_vec("seg7_1", {24'h0, seg7_1}, 32'h99);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        // ADD two-phase
        ope = 32'h0100_0000; reg_load_1 = 4'h1; reg_load_2 = 4'h5; reg_load_3 = 4'h9;
        operand = 32'd7; pulse(1, 0, 0);
        check_vec("add_p1", alu_result_bus, 32'd7);
        check_vec("add_p1_load", {28'h0, selected_reg_load}, 32'h1);
        operand = 32'd9; pulse(0, 1, 0);
        check_vec("add_p2", alu_result_bus, 32'd16);
        check_vec("add_p2_load", {28'h0, selected_reg_load}, 32'h5);
        operand = 32'hDEAD; ope = 32'h9000_0000;
        repeat (3) @(negedge clk);
        check_vec("hold_result", alu_result_bus, 32'd16);
        check_vec("hold_load", {28'h0, selected_reg_load}, 32'h5);

        // SUB: phase 2 and phase 3 both use the phase-1 latch
        ope = 32'h2900_0000;
        operand = 32'd3; pulse(1, 0, 0);
        check_vec("sub_p1", alu_result_bus, 32'd3);
        operand = 32'd5; pulse(0, 1, 0);
        check_vec("sub_p2", alu_result_bus, 32'hFFFF_FFFE);
        operand = 32'd1; pulse(0, 0, 1);
        check_vec("sub_p3", alu_result_bus, 32'd2);
        check_vec("sub_p3_load", {28'h0, selected_reg_load}, 32'h9);

        // ADD imm8 / INC / DEC wraparound
        ope = 32'h83FF_0000; operand = 32'h0; pulse(1, 0, 0);
        check_vec("addi_wrap", alu_result_bus, 32'hFFFF_FFFF);
        ope = 32'h8305_0000; operand = 32'h10; pulse(0, 1, 0);
        check_vec("addi_pos", alu_result_bus, 32'h15);
        ope = 32'h4000_0000; operand = 32'hFFFF_FFFF; pulse(1, 0, 0);
        check_vec("inc_wrap", alu_result_bus, 32'h0);
        ope = 32'h4F00_0000; operand = 32'h0; pulse(1, 0, 0);
        check_vec("dec_wrap", alu_result_bus, 32'hFFFF_FFFF);

        // PUSH / POP
        ope = 32'h5000_0000; operand = 32'h100; pulse(1, 0, 0);
        check_vec("push_p1", alu_result_bus, 32'hFC);
        pulse(0, 1, 0);
        check_vec("push_p2", alu_result_bus, 32'h100);
        ope = 32'h5F00_0000; operand = 32'h55; pulse(1, 0, 0);
        check_vec("pop_p1", alu_result_bus, 32'h55);
        operand = 32'h200; pulse(0, 1, 0);
        check_vec("pop_p2", alu_result_bus, 32'h204);

        // Branches
        ope = 32'h7410_0000; num_of_ope = 4'd2; operand = 32'h100; zero = 32'd1; pulse(1, 0, 0);
        check_vec("je_not_taken", alu_result_bus, 32'h102);
        zero = 32'd0; pulse(1, 0, 0);
        check_vec("je_taken", alu_result_bus, 32'h112);
        ope = 32'h7510_0000; zero = 32'd1; pulse(1, 0, 0);
        check_vec("jne_taken", alu_result_bus, 32'h112);
        zero = 32'd0; pulse(1, 0, 0);
        check_vec("jne_not_taken", alu_result_bus, 32'h102);
        ope = 32'hEBFE_0000; pulse(1, 0, 0);
        check_vec("jmp_back", alu_result_bus, 32'h100);

        // CMP, MOV, default EIP advance
        ope = 32'h3D05_0000; eax = 32'h10; operand = 32'h999; pulse(1, 0, 0);
        check_vec("cmp", alu_result_bus, 32'h0B);
        ope = 32'h8900_0000; operand = 32'hABCD; pulse(1, 0, 0);
        check_vec("mov", alu_result_bus, 32'hABCD);
        ope = 32'h9000_0000; num_of_ope = 4'd15; operand = 32'h1000; pulse(1, 0, 0);
        check_vec("default_adv", alu_result_bus, 32'h100F);

        // Strobe priority
        ope = 32'h0100_0000; reg_load_1 = 4'h3; reg_load_2 = 4'h6; reg_load_3 = 4'h9;
        operand = 32'd20; pulse(1, 0, 1);
        check_vec("prio13_load", {28'h0, selected_reg_load}, 32'h3);
        check_vec("prio13_result", alu_result_bus, 32'd20);
        operand = 32'd5; pulse(0, 1, 1);
        check_vec("prio23_load", {28'h0, selected_reg_load}, 32'h6);
        check_vec("prio_temp", alu_result_bus, 32'd25);

        // Reset mid-instruction clears temp
        operand = 32'd7; pulse(1, 0, 0);
        #2 reset = 1'b1;
        #1;
        check_vec("midrst_result", alu_result_bus, 32'h0);
        check_vec("midrst_load", {28'h0, selected_reg_load}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        operand = 32'd9; pulse(0, 1, 0);
        check_vec("midrst_temp0", alu_result_bus, 32'd9);

        // Display sweep of the rightmost digit
        for (int i = 0; i < 16; i++) begin
            eax = 32'h0000_1230 | 32'(i);
            #1;
            check_vec($sformatf("seg7_1_%0h", i), {24'h0, seg7_1}, {24'h0, seg_tab[i]});
            check_vec($sformatf("dp_%0h", i), {31'h0, seg7_1[7]}, 32'h1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
